// File: rtl/alu_pkg.sv
// alu_pkg: op encodings and FSM states shared by the sequential ALU family.
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: W-step LSB-first shift-add multiplier; restoring divider when ALU_DIV_EN is defined.
module alu_iter_core #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           last,
  output logic [2*W-1:0] prod_q
);
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0] cnt;
  logic [W-1:0]  b_q;
  logic          div_q;
  function automatic logic [2*W-1:0] step(input logic [2*W-1:0] p, input logic [W-1:0] d, input logic dv);
    logic [W:0] s;
`ifdef ALU_DIV_EN
    logic [W:0] r;
    logic       ge;
    r  = p[2*W-1:W-1];
    ge = r >= {1'b0, d};
`endif
    s = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, d} : '0);
`ifdef ALU_DIV_EN
    return dv ? {(ge ? r[W-1:0] - d : r[W-1:0]), p[W-2:0], ge} : {s, p[W-1:1]};
`else
    return dv ? p : {s, p[W-1:1]};
`endif
  endfunction
  assign last = cnt == '0;
  // The start edge performs the first iteration, so W-1 remain afterwards.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      prod_q <= '0;
    end else if (start) begin
      cnt    <= CW'(W - 1);
      b_q    <= b;
      div_q  <= is_div;
      prod_q <= step({{W{1'b0}}, a}, b, is_div);
    end else if (cnt != '0) begin
      cnt    <= cnt - 1'b1;
      prod_q <= step(prod_q, b_q, div_q);
    end
endmodule

// File: rtl/alu_seq_nb.sv
// alu_seq_nb: N-bit sequential ALU (add/sub/mul, div with ALU_DIV_EN) with init/busy/done handshake.
module alu_seq_nb import alu_pkg::*; #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     op,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           carry,
  output logic           zero,
  output logic           ovf
);
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  state_t         state;
  logic [1:0]     op_q, op_c;
  logic [W-1:0]   b_q;
  logic [W:0]     add_s, sub_s;
  logic [2*W-1:0] prod_q, res_c;
  logic           imm, start, last, c_c, o_c;
  always_comb begin
    op_c  = state == S_IDLE ? op : op_q;
    imm   = op != OP_MUL && (op != OP_DIV || !DIV_EN);
    start = state == S_IDLE && init && !imm;
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} - {1'b0, b};
    res_c = op_c == OP_ADD ? {{(W-1){1'b0}}, add_s} :
            op_c == OP_SUB ? {{W{sub_s[W-1]}}, sub_s[W-1:0]} :
            (op_c == OP_DIV && !DIV_EN) ? '0 : prod_q;
    c_c   = op_c == OP_ADD ? add_s[W] : op_c == OP_SUB && sub_s[W];
    o_c   = op_c == OP_SUB ? (a[W-1] != b[W-1]) && (sub_s[W-1] != a[W-1]) :
            op_c == OP_DIV && (!DIV_EN || b_q == '0);
  end
  alu_iter_core #(.W(W)) u_core (
    .clk(clk), .rst_n(rst_n), .start(start), .is_div(op == OP_DIV),
    .a(a), .b(b), .last(last), .prod_q(prod_q)
  );
  // Add/sub complete on the init edge straight from the live operands.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= init;
          if (init) begin
            op_q  <= op;
            b_q   <= b;
            state <= imm ? S_DONE : S_RUN;
            if (imm) begin
              done   <= 1'b1;
              result <= res_c;
              carry  <= c_c;
              zero   <= res_c == '0;
              ovf    <= o_c;
            end
          end
        end
        S_RUN:
          if (last) begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= res_c;
            carry  <= c_c;
            zero   <= res_c == '0;
            ovf    <= o_c;
          end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_seq_nb.sv
// tb_alu_seq_nb: directed table-driven bench for alu_seq_nb (W=3 and W=8 instances).
module tb_alu_seq_nb;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic init = 1'b0, init8 = 1'b0;
  logic [2:0] a = '0, b = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [1:0] op = '0, op8 = '0;
  logic busy, done, carry, zero, ovf;
  logic busy8, done8, carry8, zero8, ovf8;
  logic [5:0] result;
  logic [15:0] result8;
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic [1:0] op;
    logic [2:0] a, b;
    logic [5:0] res;
    logic c, z, o;
    int lat;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  alu_seq_nb #(.W(3)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .ovf(ovf)
  );
  alu_seq_nb #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .init(init8), .a(a8), .b(b8), .op(op8),
    .busy(busy8), .done(done8), .result(result8), .carry(carry8), .zero(zero8), .ovf(ovf8)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run3(input vec_t t, input string nm);
    int n = 0;
    @(negedge clk);
    op = t.op; a = t.a; b = t.b; init = 1'b1;
    do begin
      @(posedge clk); #1;
      init = 1'b0;
      n++;
      chk({nm, "_busy"}, 16'(busy), 16'd1);
    end while (!done && n < 20);
    chk({nm, "_lat"}, 16'(n), 16'(t.lat));
    chk({nm, "_res"}, 16'(result), 16'(t.res));
    chk({nm, "_carry"}, 16'(carry), 16'(t.c));
    chk({nm, "_zero"}, 16'(zero), 16'(t.z));
    chk({nm, "_ovf"}, 16'(ovf), 16'(t.o));
    @(posedge clk); #1;
    chk({nm, "_pulse"}, 16'({busy, done}), 16'd0);
  endtask
  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] er, input logic ec, input int el, input string nm);
    int n = 0;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; init8 = 1'b1;
    do begin
      @(posedge clk); #1;
      init8 = 1'b0;
      n++;
    end while (!done8 && n < 30);
    chk({nm, "_lat"}, 16'(n), 16'(el));
    chk({nm, "_res"}, result8, er);
    chk({nm, "_carry"}, 16'(carry8), 16'(ec));
    @(posedge clk); #1;
    chk({nm, "_pulse"}, 16'(done8), 16'd0);
  endtask
  initial begin
    int n, nd, first;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs", {busy, done, carry, zero, ovf, result}, 16'd0);
    chk("rst_outs8", result8 | 16'({busy8, done8, carry8, zero8, ovf8}), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v.push_back('{OP_ADD, 3'd3, 3'd4, 6'd7,        1'b0, 1'b0, 1'b0, 1});
    v.push_back('{OP_ADD, 3'd7, 3'd1, 6'b001000,   1'b1, 1'b0, 1'b0, 1});
    v.push_back('{OP_ADD, 3'd0, 3'd0, 6'd0,        1'b0, 1'b1, 1'b0, 1});
    v.push_back('{OP_SUB, 3'd2, 3'd5, 6'b111101,   1'b1, 1'b0, 1'b1, 1});
    v.push_back('{OP_SUB, 3'd3, 3'd7, 6'b111100,   1'b1, 1'b0, 1'b1, 1});
    v.push_back('{OP_SUB, 3'd5, 3'd5, 6'd0,        1'b0, 1'b1, 1'b0, 1});
    v.push_back('{OP_SUB, 3'd6, 3'd1, 6'b111101,   1'b0, 1'b0, 1'b0, 1});
    v.push_back('{OP_MUL, 3'd7, 3'd7, 6'd49,       1'b0, 1'b0, 1'b0, 4});
    v.push_back('{OP_MUL, 3'd0, 3'd5, 6'd0,        1'b0, 1'b1, 1'b0, 4});
    v.push_back('{OP_MUL, 3'd3, 3'd5, 6'd15,       1'b0, 1'b0, 1'b0, 4});
`ifdef ALU_DIV_EN
    v.push_back('{OP_DIV, 3'd7, 3'd2, {3'd1, 3'd3}, 1'b0, 1'b0, 1'b0, 4});
    v.push_back('{OP_DIV, 3'd5, 3'd0, {3'd5, 3'd7}, 1'b0, 1'b0, 1'b1, 4});
    v.push_back('{OP_DIV, 3'd6, 3'd3, {3'd0, 3'd2}, 1'b0, 1'b0, 1'b0, 4});
`else
    v.push_back('{OP_DIV, 3'd7, 3'd2, 6'd0,        1'b0, 1'b1, 1'b1, 1});
`endif
    foreach (v[i]) run3(v[i], $sformatf("v%0d", i));
    // init re-asserted during RUN must not start a second operation
    @(negedge clk);
    op = OP_MUL; a = 3'd2; b = 3'd3; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    @(negedge clk);
    op = OP_ADD; a = 3'd1; b = 3'd1; init = 1'b1;
    nd = 0; first = 0;
    for (n = 2; n < 10; n++) begin
      @(posedge clk); #1;
      init = 1'b0;
      if (done) begin
        nd++;
        if (first == 0) first = n;
      end
    end
    chk("ign_ndone", 16'(nd), 16'd1);
    chk("ign_lat", 16'(first), 16'd4);
    chk("ign_res", 16'(result), 16'd6);
    // reset in the second RUN cycle of a multiply
    @(negedge clk);
    op = OP_MUL; a = 3'd7; b = 3'd7; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy, done, carry, zero, ovf, result}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    chk("abort_nodone", 16'(nd), 16'd0);
    run3('{OP_ADD, 3'd1, 3'd1, 6'd2, 1'b0, 1'b0, 1'b0, 1}, "post_rst");
    // W=8, back-to-back operations on consecutive idle cycles
    run8(OP_MUL, 8'd255, 8'd255, 16'hFE01, 1'b0, 9, "w8_mul");
    run8(OP_MUL, 8'd16, 8'd13, 16'd208, 1'b0, 9, "w8_mul2");
    run8(OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b1, 1, "w8_add");
    run8(OP_SUB, 8'd1, 8'd2, 16'hFFFF, 1'b1, 1, "w8_sub");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
